// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, STATUS/CTRL bit indices and shared FSM state encoding for uart_mmio.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    // Byte offsets inside the 16-byte UART window
    localparam logic [3:0] UART_TXDATA = 4'h0;
    localparam logic [3:0] UART_RXDATA = 4'h4;
    localparam logic [3:0] UART_STATUS = 4'h8;
    localparam logic [3:0] UART_CTRL   = 4'hC;

    // STATUS bit indices
    localparam int ST_RX_AVAIL  = 0;
    localparam int ST_RX_FULL   = 1;
    localparam int ST_TX_FULL   = 2;
    localparam int ST_TX_EMPTY  = 3;
    localparam int ST_TX_BUSY   = 4;
    localparam int ST_RX_OVR    = 5;
    localparam int ST_FRAME_ERR = 6;
    localparam int ST_PAR_ERR   = 7;
    localparam int ST_TX_OVF    = 8;

    // CTRL bit indices
    localparam int CT_TX_EN    = 0;
    localparam int CT_RX_EN    = 1;
    localparam int CT_SOFT_RST = 2;
    localparam int CT_PAR_EN   = 3;
    localparam int CT_PAR_ODD  = 4;
    localparam int CT_RXIE     = 5;
    localparam int CT_TXIE     = 6;
    localparam int CT_DIV_LSB  = 16;

    localparam logic [15:0] DIV_MIN = 16'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_t;

    // Divisors below DIV_MIN leave too few clocks for the RX mid-bit sampling
    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, first-word fall-through (dout shows the head entry).
// Latency: a push is visible on dout / count the cycle after the pushing edge.
// Backpressure: push at full is dropped (full checked before same-cycle pop); pop at empty is a no-op.
// Ports: clk, rst (sync, active-high), push/din, pop/dout, full, empty, count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers are DEPTH-sized (power of two) so they wrap naturally
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop_ok)      r_count <= r_count + 1'b1;
            else if (!w_push_ok && w_pop_ok) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART with TX/RX FIFOs, programmable divisor, parity, sticky errors and irq.
// Latency: register read data valid the cycle after the read edge; TXDATA write to line low = 2 edges.
// Backpressure: none on the bus; TX push at full and RX byte at full are dropped and flagged sticky.
// Ports: clk, rst; bus sel_uart/mem_write/mem_read/addr/write_data/readed_data; serial data_in_rx/data_out_tx; irq.
module uart_mmio
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd868,
    parameter int          STOP_BITS  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel_uart,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [3:0]  addr,
    input  logic [31:0] write_data,
    output logic [31:0] readed_data,
    input  logic        data_in_rx,
    output logic        data_out_tx,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // ---------------- register file ----------------
    logic        r_tx_en, r_rx_en, r_par_en, r_par_odd, r_rxie, r_txie, r_soft_rst;
    logic [15:0] r_div;
    logic [3:0]  r_sticky;      // {tx_ovf, par_err, frame_err, rx_ovr}
    logic        w_clr;
    logic [3:0]  w_reg;
    logic        w_wr_tx, w_wr_stat, w_wr_ctrl, w_rd, w_rd_rx;
    logic [31:0] w_status, w_ctrl;
    logic        w_unused;

    // soft_rst clears everything except CTRL one cycle after it is written
    assign w_clr     = rst | r_soft_rst;
    assign w_reg     = {addr[3:2], 2'b00};
    assign w_rd      = sel_uart & mem_read;
    assign w_wr_tx   = sel_uart & mem_write & (w_reg == UART_TXDATA);
    assign w_wr_stat = sel_uart & mem_write & (w_reg == UART_STATUS);
    assign w_wr_ctrl = sel_uart & mem_write & (w_reg == UART_CTRL);
    assign w_rd_rx   = w_rd & (w_reg == UART_RXDATA);

    // ---------------- FIFOs ----------------
    logic          w_tx_pop, w_tx_full, w_tx_empty;
    logic [7:0]    w_tx_dout;
    logic [CW-1:0] w_tx_count;
    logic          w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic [7:0]    w_rx_dout, r_rx_shift;
    logic [CW-1:0] w_rx_count;

    assign w_rx_pop = w_rd_rx & ~w_rx_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(w_clr), .push(w_wr_tx), .pop(w_tx_pop), .din(write_data[7:0]),
        .dout(w_tx_dout), .full(w_tx_full), .empty(w_tx_empty), .count(w_tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(w_clr), .push(w_rx_push), .pop(w_rx_pop), .din(r_rx_shift),
        .dout(w_rx_dout), .full(w_rx_full), .empty(w_rx_empty), .count(w_rx_count)
    );

    // ---------------- TX engine ----------------
    uart_state_t r_tx_state, w_tx_nxt;
    logic [16:0] r_tx_cnt, w_tx_stop_len;
    logic [15:0] r_tx_div;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_shift;
    logic        r_tx_par, r_tx_par_en, w_tx_line, w_tx_bit_end, w_tx_stop_end, w_tx_busy;

    assign w_tx_busy     = (r_tx_state != S_IDLE);
    assign w_tx_stop_len = 17'(STOP_BITS) * {1'b0, r_tx_div};
    assign w_tx_bit_end  = (r_tx_cnt == {1'b0, r_tx_div} - 17'd1);
    assign w_tx_stop_end = (r_tx_cnt == w_tx_stop_len - 17'd1);

    always_comb begin
        w_tx_nxt  = r_tx_state;
        w_tx_pop  = 1'b0;
        w_tx_line = 1'b1;
        case (r_tx_state)
            S_IDLE: begin
                if (r_tx_en && !w_tx_empty) begin
                    w_tx_pop = 1'b1;
                    w_tx_nxt = S_START;
                end
            end
            S_START: begin
                w_tx_line = 1'b0;
                if (w_tx_bit_end) w_tx_nxt = S_DATA;
            end
            S_DATA: begin
                w_tx_line = r_tx_shift[0];
                if (w_tx_bit_end && r_tx_bit == 3'd7) w_tx_nxt = r_tx_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                w_tx_line = r_tx_par;
                if (w_tx_bit_end) w_tx_nxt = S_STOP;
            end
            S_STOP: begin
                if (w_tx_stop_end) w_tx_nxt = S_IDLE;
            end
            default: w_tx_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_clr) r_tx_state <= S_IDLE;
        else       r_tx_state <= w_tx_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            data_out_tx <= 1'b1;
            r_tx_cnt    <= '0;
            r_tx_bit    <= '0;
            r_tx_shift  <= '0;
            r_tx_par    <= 1'b0;
            r_tx_par_en <= 1'b0;
            r_tx_div    <= DIV_MIN;
        end else begin
            // Line is registered off the state, hence the extra edge from push to start bit
            data_out_tx <= w_tx_line;
            if (r_tx_state == S_IDLE) begin
                r_tx_cnt <= '0;
                r_tx_bit <= '0;
                if (w_tx_pop) begin
                    // Framing parameters are frozen for the whole frame
                    r_tx_shift  <= w_tx_dout;
                    r_tx_par    <= (^w_tx_dout) ^ r_par_odd;
                    r_tx_par_en <= r_par_en;
                    r_tx_div    <= clamp_div(r_div);
                end
            end else begin
                if (w_tx_nxt != r_tx_state || (r_tx_state == S_DATA && w_tx_bit_end)) r_tx_cnt <= '0;
                else                                                                  r_tx_cnt <= r_tx_cnt + 17'd1;
                if (r_tx_state == S_DATA && w_tx_bit_end) begin
                    r_tx_shift <= r_tx_shift >> 1;
                    r_tx_bit   <= r_tx_bit + 3'd1;
                end
            end
        end
    end

    // ---------------- RX engine ----------------
    uart_state_t r_rx_state, w_rx_nxt;
    logic        r_rx_s1, r_rx_s2, r_rx_s3;   // s1/s2 synchroniser, s3 edge history
    logic [15:0] r_rx_cnt, r_rx_div;
    logic [2:0]  r_rx_bit;
    logic        r_rx_pbit, r_rx_par_en, r_rx_par_odd;
    logic        w_rx_fall, w_rx_half, w_rx_bit_end;
    logic        w_ovr_evt, w_frame_evt, w_par_evt, w_tx_ovf_evt;

    assign w_rx_fall    = r_rx_s3 & ~r_rx_s2;
    assign w_rx_half    = (r_rx_cnt == (r_rx_div >> 1) - 16'd1);
    assign w_rx_bit_end = (r_rx_cnt == r_rx_div - 16'd1);

    always_comb begin
        w_rx_nxt    = r_rx_state;
        w_rx_push   = 1'b0;
        w_frame_evt = 1'b0;
        w_par_evt   = 1'b0;
        w_ovr_evt   = 1'b0;
        case (r_rx_state)
            S_IDLE:   if (r_rx_en && w_rx_fall) w_rx_nxt = S_START;
            // A start bit that is high again at mid-bit was a glitch
            S_START:  if (w_rx_half) w_rx_nxt = r_rx_s2 ? S_IDLE : S_DATA;
            S_DATA:   if (w_rx_bit_end && r_rx_bit == 3'd7) w_rx_nxt = r_rx_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (w_rx_bit_end) w_rx_nxt = S_STOP;
            S_STOP: begin
                if (w_rx_bit_end) begin
                    w_rx_nxt = S_IDLE;
                    if (!r_rx_s2)                                                      w_frame_evt = 1'b1;
                    else if (r_rx_par_en && ((^r_rx_shift) ^ r_rx_pbit ^ r_rx_par_odd)) w_par_evt   = 1'b1;
                    else if (w_rx_full)                                                w_ovr_evt   = 1'b1;
                    else                                                               w_rx_push   = 1'b1;
                end
            end
            default: w_rx_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_clr) r_rx_state <= S_IDLE;
        else       r_rx_state <= w_rx_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            {r_rx_s1, r_rx_s2, r_rx_s3} <= 3'b111;
            r_rx_cnt     <= '0;
            r_rx_div     <= DIV_MIN;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_pbit    <= 1'b0;
            r_rx_par_en  <= 1'b0;
            r_rx_par_odd <= 1'b0;
        end else begin
            r_rx_s1 <= data_in_rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
            if (r_rx_state == S_IDLE) begin
                r_rx_cnt     <= '0;
                r_rx_bit     <= '0;
                r_rx_div     <= clamp_div(r_div);
                r_rx_par_en  <= r_par_en;
                r_rx_par_odd <= r_par_odd;
            end else begin
                if (w_rx_nxt != r_rx_state || (r_rx_state == S_DATA && w_rx_bit_end)) r_rx_cnt <= '0;
                else                                                                  r_rx_cnt <= r_rx_cnt + 16'd1;
                if (r_rx_state == S_DATA && w_rx_bit_end) begin
                    r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                    r_rx_bit   <= r_rx_bit + 3'd1;
                end
                if (r_rx_state == S_PARITY && w_rx_bit_end) r_rx_pbit <= r_rx_s2;
            end
        end
    end

    // ---------------- CTRL / STATUS / read path / irq ----------------
    assign w_tx_ovf_evt = w_wr_tx & w_tx_full;

    assign w_status = {23'b0, r_sticky, w_tx_busy, w_tx_empty, w_tx_full, w_rx_full, ~w_rx_empty};
    assign w_ctrl   = {r_div, 9'b0, r_txie, r_rxie, r_par_odd, r_par_en, 1'b0, r_rx_en, r_tx_en};

    // write_data[15:9] and addr[1:0] have no register behind them
    assign w_unused = ^{write_data[15:9], addr[1:0], w_tx_count, w_rx_count};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_en    <= 1'b1;
            r_rx_en    <= 1'b1;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_rxie     <= 1'b0;
            r_txie     <= 1'b0;
            r_div      <= DIV_RESET;
            r_soft_rst <= 1'b0;
        end else begin
            r_soft_rst <= w_wr_ctrl & write_data[CT_SOFT_RST];
            if (w_wr_ctrl) begin
                r_tx_en   <= write_data[CT_TX_EN];
                r_rx_en   <= write_data[CT_RX_EN];
                r_par_en  <= write_data[CT_PAR_EN];
                r_par_odd <= write_data[CT_PAR_ODD];
                r_rxie    <= write_data[CT_RXIE];
                r_txie    <= write_data[CT_TXIE];
                r_div     <= write_data[CT_DIV_LSB +: 16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_sticky    <= '0;
            readed_data <= '0;
            irq         <= 1'b0;
        end else begin
            // Set term is OR-ed after the clear mask so a coincident event survives
            r_sticky <= (r_sticky & ~(w_wr_stat ? write_data[ST_TX_OVF:ST_RX_OVR] : 4'b0))
                      | {w_tx_ovf_evt, w_par_evt, w_frame_evt, w_ovr_evt};
            irq <= (r_rxie & ~w_rx_empty) | (r_txie & w_tx_empty & ~w_tx_busy);
            if (w_rd) begin
                case (w_reg)
                    UART_RXDATA: readed_data <= w_rx_empty ? 32'h0 : {24'h0, w_rx_dout};
                    UART_STATUS: readed_data <= w_status;
                    UART_CTRL:   readed_data <= w_ctrl;
                    default:     readed_data <= 32'h0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: self-checking bench for uart_mmio with read/TX/RX scoreboards.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_mmio;
    logic        clk = 1'b0;
    logic        rst, sel_uart, mem_write, mem_read;
    logic [3:0]  addr;
    logic [31:0] write_data, readed_data;
    logic        data_in_rx, data_out_tx, irq;

    always #5 clk = ~clk;

    uart_mmio #(.FIFO_DEPTH(16), .DIV_RESET(16'd868), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .sel_uart(sel_uart), .mem_write(mem_write), .mem_read(mem_read),
        .addr(addr), .write_data(write_data), .readed_data(readed_data),
        .data_in_rx(data_in_rx), .data_out_tx(data_out_tx), .irq(irq)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] q_rd[$];
    logic [7:0]  q_tx[$];
    logic [7:0]  q_rx[$];
    int          tb_div = 4;
    bit          tb_par_en = 1'b0;
    bit          tb_par_odd = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        sel_uart = 1'b1; mem_write = 1'b1; addr = a; write_data = d;
        tick(1);
        sel_uart = 1'b0; mem_write = 1'b0;
    endtask

    task automatic bus_read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        q_rd.push_back(exp);
        sel_uart = 1'b1; mem_read = 1'b1; addr = a;
        tick(1);
        sel_uart = 1'b0; mem_read = 1'b0;
        check_val(tag, readed_data, q_rd.pop_front());
    endtask

    task automatic rx_read_chk(input string tag);
        logic [31:0] e;
        e = 32'h0;
        if (q_rx.size() > 0) e = {24'h0, q_rx.pop_front()};
        bus_read_chk(tag, 4'h4, e);
    endtask

    task automatic drive_bit(input logic b);
        data_in_rx = b;
        tick(tb_div);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic par_flip, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (tb_par_en) drive_bit((^d) ^ tb_par_odd ^ par_flip);
        drive_bit(stop_bit);
        data_in_rx = 1'b1;
        tick(3 * tb_div);
    endtask

    // Decode n TX frames at mid-bit and compare against the TX scoreboard
    task automatic tx_collect(input int n);
        for (int k = 0; k < n; k++) begin
            logic [10:0] obs;
            logic [10:0] exp;
            logic [7:0]  b;
            int          w;
            w = 0;
            while (data_out_tx !== 1'b0 && w < 2000) begin
                tick(1);
                w++;
            end
            if (w >= 2000) begin
                check_val("tx_start_timeout", data_out_tx, 0);
                return;
            end
            obs = '0;
            tick(tb_div / 2);
            obs[0] = data_out_tx;
            for (int i = 0; i < 8; i++) begin
                tick(tb_div);
                obs[1 + i] = data_out_tx;
            end
            if (tb_par_en) begin
                tick(tb_div);
                obs[9] = data_out_tx;
            end
            tick(tb_div);
            obs[10] = data_out_tx;
            b = (q_tx.size() > 0) ? q_tx.pop_front() : 8'h00;
            exp = {1'b1, tb_par_en ? ((^b) ^ tb_par_odd) : 1'b0, b, 1'b0};
            check_val($sformatf("tx_frame%0d", k), obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] wave_obs, wave_exp;
        logic [7:0]  b;
        int          lows;

        rst = 1'b1; sel_uart = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
        addr = 4'h0; write_data = 32'h0; data_in_rx = 1'b1;

        // Reset
        tick(2);
        rst = 1'b0;
        check_val("rst_line", data_out_tx, 1);
        check_val("rst_irq", irq, 0);
        check_val("rst_rdata", readed_data, 0);
        bus_read_chk("rst_ctrl", 4'hC, 32'h0364_0003);
        bus_read_chk("rst_status", 4'h8, 32'h0000_0008);

        // 8N1 TX, exact per-clock waveform
        bus_write(4'hC, 32'h0004_0003);
        bus_write(4'h0, 32'h0000_0055);
        tick(1);
        check_val("tx_pre_start", data_out_tx, 1);
        b = 8'h55;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            wave_obs[k] = data_out_tx;
            if (k / 4 == 0)      wave_exp[k] = 1'b0;
            else if (k / 4 == 9) wave_exp[k] = 1'b1;
            else                 wave_exp[k] = b[k / 4 - 1];
        end
        check_val("tx_8n1_wave", wave_obs, wave_exp);
        tick(1);
        check_val("tx_idle_after", data_out_tx, 1);
        bus_read_chk("status_tx_done", 4'h8, 32'h0000_0008);

        // Parity TX (even then odd), then even-parity RX with rxie
        bus_write(4'hC, 32'h0004_002B);
        tb_par_en = 1'b1; tb_par_odd = 1'b0;
        q_tx.push_back(8'h07);
        bus_write(4'h0, 32'h0000_0007);
        tx_collect(1);
        tick(2 * tb_div);
        bus_write(4'hC, 32'h0004_003B);
        tb_par_odd = 1'b1;
        q_tx.push_back(8'hA5);
        bus_write(4'h0, 32'h0000_00A5);
        tx_collect(1);
        tick(2 * tb_div);
        bus_write(4'hC, 32'h0004_002B);
        tb_par_odd = 1'b0;

        q_rx.push_back(8'hA5);
        drive_frame(8'hA5, 1'b0, 1'b1);
        check_val("irq_rx", irq, 1);
        bus_read_chk("status_rx", 4'h8, 32'h0000_0009);
        rx_read_chk("rxdata_a5");
        tick(1);
        check_val("irq_rx_clear", irq, 0);

        // Framing and parity errors, then W1C
        drive_frame(8'h3C, 1'b0, 1'b0);
        bus_read_chk("status_frame_err", 4'h8, 32'h0000_0048);
        drive_frame(8'h3C, 1'b1, 1'b1);
        bus_read_chk("status_par_err", 4'h8, 32'h0000_00C8);
        rx_read_chk("rx_empty_after_err");
        bus_write(4'h8, 32'h0000_00C0);
        bus_read_chk("status_w1c", 4'h8, 32'h0000_0008);

        // TX overflow: 17 writes with tx disabled, only 16 go out
        bus_write(4'hC, 32'h0004_0002);
        tb_par_en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            b = 8'(i * 13 + 1);
            if (i < 16) q_tx.push_back(b);
            bus_write(4'h0, {24'h0, b});
        end
        bus_read_chk("status_tx_ovf", 4'h8, 32'h0000_0104);
        bus_write(4'hC, 32'h0004_0003);
        tx_collect(16);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (data_out_tx == 1'b0) lows++;
        end
        check_val("tx_no_17th", lows, 0);
        bus_read_chk("status_tx_drained", 4'h8, 32'h0000_0108);
        bus_write(4'h8, 32'h0000_0100);

        // RX overflow: 17 frames, 16 kept in order
        for (int i = 0; i < 17; i++) begin
            b = 8'(i * 29 + 7);
            if (i < 16) q_rx.push_back(b);
            drive_frame(b, 1'b0, 1'b1);
        end
        bus_read_chk("status_rx_ovr", 4'h8, 32'h0000_002B);
        for (int i = 0; i < 16; i++) rx_read_chk($sformatf("rx_ovf_byte%0d", i));
        rx_read_chk("rx_empty_read");
        bus_write(4'h8, 32'h0000_0020);
        bus_read_chk("status_clean", 4'h8, 32'h0000_0008);

        // Soft reset mid-frame
        drive_frame(8'h11, 1'b0, 1'b1);
        bus_write(4'h0, 32'h0000_003C);
        bus_write(4'h0, 32'h0000_003D);
        bus_write(4'h0, 32'h0000_003E);
        tick(5);
        bus_read_chk("status_busy", 4'h8, 32'h0000_0011);
        bus_write(4'hC, 32'h0004_0007);
        tick(1);
        check_val("srst_line", data_out_tx, 1);
        check_val("srst_rdata", readed_data, 0);
        bus_read_chk("srst_status", 4'h8, 32'h0000_0008);
        bus_read_chk("srst_ctrl", 4'hC, 32'h0004_0003);
        rx_read_chk("srst_rx_empty");
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (data_out_tx == 1'b0) lows++;
        end
        check_val("srst_tx_quiet", lows, 0);

        // TX-empty interrupt
        bus_write(4'hC, 32'h0004_0043);
        tick(1);
        check_val("irq_txie", irq, 1);
        bus_write(4'hC, 32'h0004_0003);
        tick(1);
        check_val("irq_txie_off", irq, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_mmio.md
# uart_mmio

Parametrised memory-mapped UART replacing the single-byte UART register window. It sits on the data bus at 0x80000000–0x8000000F, decoded by `sel_uart`. It adds TX and RX FIFOs, a programmable baud divisor, optional parity, sticky error flags and an interrupt line. TX and RX framing engines are internal; there are no external `tx`/`rx` instances.

## Interface
- `FIFO_DEPTH`, 16, entries per TX/RX FIFO; power of two, 2–256.
- `DIV_RESET`, 16'd868, reset baud divisor in clocks per bit (100 MHz / 115200).
- `STOP_BITS`, 1, number of stop bits; 1 or 2.

Ports:
- `clk` input 1: sole clock.
- `rst` input 1: synchronous, active-high reset.
- `sel_uart` input 1: window select from the address decoder.
- `mem_write` input 1: write strobe, qualified by `sel_uart`.
- `mem_read` input 1: read strobe, qualified by `sel_uart`.
- `addr` input 4: byte offset in the window; bits [1:0] ignored (word access only).
- `write_data` input 32: write data.
- `readed_data` output 32: registered read data.
- `data_in_rx` input 1: asynchronous serial input.
- `data_out_tx` output 1: serial output, idles high.
- `irq` output 1: level interrupt.

## Operation
Register map (offset, behaviour):
- **0x0 TXDATA**
  - Write pushes `write_data[7:0]` into the TX FIFO.
  - A push when the FIFO is full is dropped and sets `tx_ovf`.
  - Reads return 0.
- **0x4 RXDATA**
  - A read pops the RX FIFO and returns {24'b0, byte}.
  - A read when empty returns 0 and pops nothing.
  - Writes are ignored.
- **0x8 STATUS**
  - Bit 0: `rx_avail`. Bit 1: `rx_full`. Bit 2: `tx_full`. Bit 3: `tx_empty`. Bit 4: `tx_busy` (FSM not IDLE).
  - Sticky bits: 5 `rx_ovr`, 6 `frame_err`, 7 `par_err`, 8 `tx_ovf`.
  - Sticky bits are write-1-to-clear.
  - If a set event and a clear land in the same cycle, the set wins.
- **0xC CTRL**
  - Bit 0: `tx_en`. Bit 1: `rx_en`. Bit 2: `soft_rst` (self-clearing, reads 0). Bit 3: `par_en`. Bit 4: `par_odd`. Bit 5: `rxie`. Bit 6: `txie`.
  - Bits [31:16]: `div`. A divisor below 4 is treated as 4.
  - Reset value: {DIV_RESET, 16'h0003}.

Interrupt:
- `irq` = (`rxie` & `rx_avail`) | (`txie` & `tx_empty` & !`tx_busy`), registered.

TX FSM: IDLE → START → DATA → PARITY → STOP → IDLE.
- IDLE leaves when `tx_en` is set and the FIFO is not empty; it pops one byte.
- Data is sent LSB first, 8 bits.
- The PARITY state is skipped when `par_en` = 0. Even parity sets the parity bit so the total count of ones is even; odd parity makes it odd.
- STOP lasts `STOP_BITS` × `div` clocks.
- Clearing `tx_en` mid-frame finishes the current frame and then holds IDLE.

RX FSM: IDLE → START → DATA → PARITY → STOP → IDLE.
- Input passes through a 2-flop synchroniser.
- A falling edge in IDLE with `rx_en` = 1 starts reception.
- The start bit is re-sampled at `div`/2. If it is high, the FSM returns to IDLE with no error.
- Each subsequent bit is sampled every `div` clocks.
- Only the first stop bit is checked. A low stop bit sets `frame_err` and discards the byte.
- A parity mismatch sets `par_err` and discards the byte.
- A good byte arriving with the RX FIFO full is dropped and sets `rx_ovr`.

FIFO boundary rules:
- Pointers wrap modulo `FIFO_DEPTH`. Count width is $clog2(FIFO_DEPTH)+1.
- A push is evaluated against full before any same-cycle pop, so a push at full is always dropped.
- A pop when empty is a no-op.
- A simultaneous push and pop at non-full, non-empty leaves the count unchanged.

## Timing
Reset (`rst`, or `soft_rst` one cycle after it is written):
- `data_out_tx` = 1, `readed_data` = 0, `irq` = 0.
- FIFOs empty, FSMs IDLE, sticky bits 0.
- `rst` also restores CTRL. `soft_rst` leaves CTRL intact apart from bit 2.
- A frame in progress is aborted and the line returns high immediately.

Read:
- `readed_data` is loaded on the edge where `sel_uart & mem_read` is sampled and is valid the following cycle.
- It holds its value when there is no read.
- The RX pop takes effect on that same edge.

Write:
- Registers and FIFO update on the sampling edge.
- A TXDATA write at edge N with TX IDLE, `tx_en` = 1 and the FIFO empty gives `data_out_tx` low after edge N+2.

Bit timing:
- Each bit lasts exactly `div` clocks.
- A full 8N1 frame takes 10×`div` clocks; 8E1 takes 11×`div`.
- A new `div` takes effect at the next frame start.

## Structure
- Package `uart_pkg`:
  - Register offsets (`UART_TXDATA`, `UART_RXDATA`, `UART_STATUS`, `UART_CTRL`).
  - STATUS/CTRL bit indices.
  - Shared TX/RX state encoding: IDLE, START, DATA, PARITY, STOP.
- Sub-module `sync_fifo` (params `WIDTH`, `DEPTH`): ports `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`. It is instantiated twice.
- The TX and RX FSMs and the register file stay in `uart_mmio`.

## Test plan
- **Reset:** assert `rst` 2 cycles → `data_out_tx` = 1, `irq` = 0; read 0xC returns 0x03640003; read 0x8 returns 0x00000008.
- **8N1 TX:** `div` = 4, write 0x55 to 0x0 → line low after edge N+2, then bits 1,0,1,0,1,0,1,0, stop high, 4 clocks each, 40 clocks total.
- **RX loopback with even parity:** `par_en` = 1, `rxie` = 1, drive 0xA5 with parity 0 → `rx_avail`, `irq` = 1; read 0x4 returns 0x000000A5, then `irq` = 0.
- **Errors:**
  - Drive a low stop bit → `frame_err` set, FIFO empty.
  - Wrong parity → `par_err` set.
  - Write 0x000000C0 to 0x8 → both flags clear.
- **Overflow:** `tx_en` = 0, write 17 bytes with depth 16 → `tx_full` = 1, `tx_ovf` = 1, only the first 16 are transmitted after `tx_en` = 1. RX 17 frames without reads → `rx_ovr` = 1, 16 bytes read back in order.
- **Soft reset mid-frame:** write CTRL bit 2 during the TX DATA state → line high next cycle, FIFOs empty, CTRL `div` retained.
